uart_tx_buffer: RTL and testbench
=================================

// Module: uart_tx_buffer
// PURPOSE
//  Byte FIFO plus transmit sequencer between uart_rx (producer) and uart_tx (consumer).
//  Absorbs back-to-back received bytes while uart_tx is busy, then replays them one at a time
//  using the uart_tx en/busy handshake. Replaces the direct rx_valid->tx_en loopback path in the
//  top level. Also exposes fill level and a sticky overflow flag for LEDs and debug.
// PARAMETERS
//  PAYLOAD_BITS  8   width of one UART word; must match uart_rx/uart_tx
//  DEPTH         16  FIFO entries; power of two, >= 2
//  ADDR_W        $clog2(DEPTH)  local; pointer width (pointers are ADDR_W+1 bits incl. wrap bit)
// PORTS
//  clk            in   1             system clock; all logic on posedge
//  resetn         in   1             asynchronous active-low reset
//  in_valid       in   1             one-cycle strobe from uart_rx_valid
//  in_data        in   PAYLOAD_BITS  byte from uart_rx_data, sampled when in_valid=1
//  in_break       in   1             uart_rx_break; level, flushes FIFO while high
//  clr_overflow   in   1             clears the sticky overflow flag
//  tx_busy        in   1             uart_tx_busy
//  tx_en          out  1             one-cycle start strobe to uart_tx_en (registered)
//  tx_data        out  PAYLOAD_BITS  byte to uart_tx_data (registered); held until next launch
//  fill_level     out  ADDR_W+1      entries currently stored, 0..DEPTH
//  empty          out  1             fill_level==0
//  full           out  1             fill_level==DEPTH
//  overflow       out  1             sticky: a push was dropped because FIFO was full
// BEHAVIOUR
//  Reset (async assert, sync release): pointers=0, state=IDLE, tx_en=0, tx_data=0,
//   overflow=0, fill_level=0, empty=1, full=0.
//  Push: in_valid=1 and (!full or pop in the same cycle) -> write in_data at wr_ptr, wr_ptr+1.
//   in_valid=1 while full and no same-cycle pop -> byte dropped, overflow<=1, pointers unchanged.
//  Pointers wrap modulo DEPTH; full = MSBs differ and low bits equal; empty = pointers equal.
//  Sequencer FSM (registered):
//   IDLE  : if !empty && !tx_busy -> LAUNCH. Otherwise stay.
//   LAUNCH: tx_en<=1 and tx_data<=mem[rd_ptr] for exactly one cycle; pop (rd_ptr+1); -> GUARD.
//   GUARD : one cycle, tx_busy ignored (covers uart_tx's one-cycle busy rise latency); -> WAIT.
//   WAIT  : stay while tx_busy=1; tx_busy=0 -> IDLE.
//  Latency: byte pushed at edge N into empty FIFO with tx idle -> IDLE sees !empty in cycle N+1
//   -> tx_en high in cycle N+2. Minimum spacing between tx_en pulses = 4 cycles plus the busy time.
//  Simultaneous push and pop: both take effect; fill_level unchanged; allowed when full or empty
//   (pop never occurs when empty because LAUNCH requires !empty at IDLE).
//  in_break=1: pointers reset to equal (flush) each cycle; pushes ignored, overflow not set;
//   FSM: IDLE stays IDLE; a byte already launched completes normally (GUARD/WAIT run out).
//  clr_overflow=1 and a dropped push in the same cycle: overflow stays 1 (set wins).
//  resetn asserted mid-transmission: everything returns to reset values immediately; tx_en
//   drops to 0; any partially sent frame is uart_tx's concern (it shares resetn).
//  fill_level = wr_ptr - rd_ptr, (ADDR_W+1)-bit wrap-around subtraction.
// STRUCTURE
//  uart_pkg: shared PAYLOAD_BITS default, CLK_HZ/BIT_RATE defaults, FSM state encoding
//   (IDLE=2'd0, LAUNCH=2'd1, GUARD=2'd2, WAIT=2'd3).
//  One sub-module: uart_byte_fifo (storage, pointers, full/empty/fill_level, flush input);
//   uart_tx_buffer holds the FSM, overflow flag and output registers.
//  Storage: plain register array, no reset on the data array, only on the pointers.
// TESTING
//  1 Reset: resetn=0 mid-run -> tx_en=0, tx_data=0, fill_level=0, empty=1, overflow=0 same cycle.
//  2 Single byte 0xA5, tx_busy model idle -> tx_en pulses exactly once, 2 cycles after push,
//    tx_data=0xA5, fill_level returns to 0.
//  3 Burst 0x01..0x05 on consecutive in_valid while tx_busy held 1 for 100 cycles -> fill_level=5;
//    after busy drops, tx_data sequence 0x01..0x05 in order, each separated by busy high period.
//  4 DEPTH=16: push 17 bytes with tx_busy=1 -> full=1, overflow=1, 17th byte lost; clr_overflow
//    -> overflow=0; drained order = first 16 bytes.
//  5 Full FIFO, push coinciding with LAUNCH pop -> byte accepted, overflow stays 0, fill_level=16.
//  6 in_break=1 with 6 bytes queued -> fill_level=0 next cycle, no further tx_en after the
//    in-flight frame; pushes during break ignored; after break low, new byte 0x3C transmits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART defaults and the transmit-sequencer state encoding.
package uart_pkg;

  localparam int unsigned PAYLOAD_BITS_DEF = 8;
  localparam int unsigned DEPTH_DEF        = 16;
  localparam int unsigned CLK_HZ_DEF       = 50_000_000;
  localparam int unsigned BIT_RATE_DEF     = 9600;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_LAUNCH = 2'd1;
  localparam logic [ST_W-1:0] ST_GUARD  = 2'd2;
  localparam logic [ST_W-1:0] ST_WAIT   = 2'd3;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer/consumer-side signals of the UART transmit buffer.
interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                    in_valid;
  logic [PAYLOAD_BITS-1:0] in_data;
  logic                    in_break;
  logic                    clr_overflow;
  logic                    tx_busy;
  logic                    tx_en;
  logic [PAYLOAD_BITS-1:0] tx_data;
  logic [ADDR_W:0]         fill_level;
  logic                    empty;
  logic                    full;
  logic                    overflow;

  modport master (
    output in_valid, in_data, in_break, clr_overflow, tx_busy,
    input  tx_en, tx_data, fill_level, empty, full, overflow
  );

  modport slave (
    input  in_valid, in_data, in_break, clr_overflow, tx_busy,
    output tx_en, tx_data, fill_level, empty, full, overflow
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with wrap-bit pointers and a synchronous flush.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic                        i_flush,
  input  logic [PAYLOAD_BITS-1:0]     i_data,
  output logic [PAYLOAD_BITS-1:0]     o_rd_data,
  output logic [$clog2(DEPTH):0]      o_fill,
  output logic                        o_empty,
  output logic                        o_full
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;

  // Storage array is intentionally left without reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
    end
  end

  // Flush collapses both pointers so all stored bytes are discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_fill    = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers received UART bytes and replays them to uart_tx via the en/busy handshake.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  uart_tx_buffer_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ST_W-1:0]         r_state;
  logic [ST_W-1:0]         w_state_nxt;
  logic                    w_launch;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic                    r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  logic                    r_overflow;
  logic [PAYLOAD_BITS-1:0] w_rd_data;
  logic [ADDR_W:0]         w_fill;
  logic                    w_empty;
  logic                    w_full;

  uart_byte_fifo #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .DEPTH        (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (bus.in_break),
    .i_data    (bus.in_data),
    .o_rd_data (w_rd_data),
    .o_fill    (w_fill),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  // The launched byte leaves the FIFO at the end of the LAUNCH cycle.
  assign w_pop  = (r_state == ST_LAUNCH);
  assign w_push = bus.in_valid && !bus.in_break && (!w_full || w_pop);
  assign w_drop = bus.in_valid && !bus.in_break && w_full && !w_pop;

  // Sequencer next state; GUARD skips tx_busy while uart_tx raises it.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !bus.tx_busy && !bus.in_break) begin
          w_state_nxt = ST_LAUNCH;
          w_launch    = 1'b1;
        end
      end
      ST_LAUNCH: w_state_nxt = ST_GUARD;
      ST_GUARD:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!bus.tx_busy) w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // tx_en is high exactly while in LAUNCH; tx_data holds until the next launch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tx_en <= w_launch;
      if (w_launch) r_tx_data <= w_rd_data;
      if (w_drop)                 r_overflow <= 1'b1;
      else if (bus.clr_overflow)  r_overflow <= 1'b0;
    end
  end

  assign bus.tx_en      = r_tx_en;
  assign bus.tx_data    = r_tx_data;
  assign bus.overflow   = r_overflow;
  assign bus.fill_level = w_fill;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized and directed bench for uart_tx_buffer against a queue-based reference model.
module tb_uart_tx_buffer;
  localparam int unsigned PB    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) bus ();

  uart_tx_buffer #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, sticky flag, and a "transmitter free" notion.
  logic [PB-1:0] m_q[$];
  bit            m_ovf  = 1'b0;
  bit            m_en   = 1'b0;
  bit            m_free = 1'b1;
  logic [PB-1:0] m_data = '0;
  int            m_cyc  = 0;

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_q.delete();
      m_ovf = 1'b0; m_en = 1'b0; m_data = '0; m_free = 1'b1; m_cyc = 0;
    end else begin : step
      bit launching, next_en, drop;
      launching = m_en;
      next_en   = m_free && (m_q.size() > 0) && !bus.tx_busy && !bus.in_break;
      if (next_en) m_data = m_q[0];
      drop = 1'b0;
      if (bus.in_break) m_q.delete();
      else begin
        if (launching) void'(m_q.pop_front());
        if (bus.in_valid) begin
          if (m_q.size() < int'(DEPTH)) m_q.push_back(bus.in_data);
          else drop = 1'b1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (bus.clr_overflow) m_ovf = 1'b0;
      // After a launch, one launch cycle and one blind cycle pass, then busy must read low.
      if (next_en) begin
        m_free = 1'b0; m_cyc = 0;
      end else if (!m_free) begin
        if (m_cyc >= 2 && !bus.tx_busy) m_free = 1'b1;
        else m_cyc++;
      end
      m_en = next_en;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_tx_en",   32'(bus.tx_en),      32'(m_en));
    chk("cyc_tx_data", 32'(bus.tx_data),    32'(m_data));
    chk("cyc_fill",    32'(bus.fill_level), 32'(m_q.size()));
    chk("cyc_empty",   32'(bus.empty),      32'(m_q.size() == 0));
    chk("cyc_full",    32'(bus.full),       32'(m_q.size() == int'(DEPTH)));
    chk("cyc_ovf",     32'(bus.overflow),   32'(m_ovf));
  end

  // uart_tx stand-in: 0 = busy rises one cycle after tx_en for busy_len cycles.
  int busy_mode = 3;
  int busy_len  = 0;
  int busy_cnt  = 0;
  bit launch_seen = 1'b0;

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (busy_mode)
        1: bus.tx_busy = 1'b1;
        2: bus.tx_busy = 1'($urandom_range(0, 1));
        3: bus.tx_busy = 1'b0;
        default: begin
          if (launch_seen && busy_len > 0) begin
            bus.tx_busy = 1'b1;
            busy_cnt    = busy_len - 1;
          end else if (busy_cnt > 0) busy_cnt--;
          else bus.tx_busy = 1'b0;
          launch_seen = bus.tx_en;
        end
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [PB-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_tx(input int budget, output bit got, output logic [PB-1:0] d, output int cyc);
    got = 1'b0; d = '0; cyc = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (bus.tx_en) begin
        got = 1'b1; d = bus.tx_data; cyc = k;
        break;
      end
    end
  endtask

  initial begin : main
    bit            got;
    logic [PB-1:0] d;
    int            cyc;
    int            n;
    logic [PB-1:0] b [17];

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_break = 1'b0; bus.clr_overflow = 1'b0;
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    chk("rst_tx_en", 32'(bus.tx_en),      32'd0);
    chk("rst_empty", 32'(bus.empty),      32'd1);
    chk("rst_fill",  32'(bus.fill_level), 32'd0);
    chk("rst_ovf",   32'(bus.overflow),   32'd0);

    // Single byte, transmitter idle.
    busy_mode = 3; tick(2);
    push(8'hA5);
    wait_tx(10, got, d, cyc);
    chk("t2_got",  32'(got), 32'd1);
    chk("t2_data", 32'(d),   32'hA5);
    chk("t2_lat",  32'(cyc), 32'd1);
    n = 0;
    repeat (30) begin tick(1); if (bus.tx_en) n++; end
    chk("t2_once", 32'(n), 32'd0);
    chk("t2_fill", 32'(bus.fill_level), 32'd0);

    // Burst absorbed while busy, replayed in order.
    busy_mode = 1; tick(2);
    for (int i = 1; i <= 5; i++) push(8'(i));
    tick(100);
    chk("t3_fill", 32'(bus.fill_level), 32'd5);
    busy_len = 20; busy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      wait_tx(200, got, d, cyc);
      chk("t3_got",  32'(got), 32'd1);
      chk("t3_data", 32'(d),   32'(i + 1));
      if (i > 0) chk("t3_gap", 32'(cyc), 32'(busy_len + 3));
    end
    tick(40);
    chk("t3_fill_end", 32'(bus.fill_level), 32'd0);

    // Overflow on the 17th byte, clear, then push during a full-FIFO launch.
    busy_mode = 1; tick(2);
    for (int i = 0; i < 17; i++) begin
      b[i] = 8'($urandom);
      push(b[i]);
    end
    chk("t4_full", 32'(bus.full),       32'd1);
    chk("t4_fill", 32'(bus.fill_level), 32'd16);
    chk("t4_ovf",  32'(bus.overflow),   32'd1);
    bus.clr_overflow = 1'b1; tick(1); bus.clr_overflow = 1'b0;
    chk("t4_clr", 32'(bus.overflow), 32'd0);
    busy_len = 5; busy_mode = 0;
    wait_tx(20, got, d, cyc);
    chk("t5_got",   32'(got), 32'd1);
    chk("t4_first", 32'(d),   32'(b[0]));
    bus.in_valid = 1'b1; bus.in_data = 8'h77;
    tick(1);
    bus.in_valid = 1'b0;
    chk("t5_ovf",  32'(bus.overflow),   32'd0);
    chk("t5_fill", 32'(bus.fill_level), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      wait_tx(100, got, d, cyc);
      chk("t4_drain_got", 32'(got), 32'd1);
      chk("t4_drain", 32'(d), (i < 16) ? 32'(b[i]) : 32'h77);
    end
    tick(30);

    // Break flushes queued bytes; in-flight frame completes; recovery afterwards.
    busy_len = 30; busy_mode = 0;
    for (int i = 0; i < 7; i++) push(8'(8'h40 + i));
    tick(2);
    chk("t6_queued", 32'(bus.fill_level), 32'd6);
    bus.in_break = 1'b1;
    tick(1);
    chk("t6_flush", 32'(bus.fill_level), 32'd0);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      bus.in_valid = (k % 3 == 0);
      bus.in_data  = 8'hEE;
      tick(1);
      if (bus.tx_en) n++;
    end
    bus.in_valid = 1'b0;
    chk("t6_no_tx",  32'(n), 32'd0);
    chk("t6_fill",   32'(bus.fill_level), 32'd0);
    chk("t6_ovf",    32'(bus.overflow), 32'd0);
    bus.in_break = 1'b0;
    tick(2);
    push(8'h3C);
    wait_tx(20, got, d, cyc);
    chk("t6_got",  32'(got), 32'd1);
    chk("t6_data", 32'(d),   32'h3C);
    tick(40);

    // Randomized traffic with random busy.
    busy_mode = 2;
    for (int k = 0; k < 3000; k++) begin
      bus.in_valid     = (k < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus.in_data      = 8'($urandom);
      bus.in_break     = ($urandom_range(0, 299) == 0);
      bus.clr_overflow = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    bus.in_valid = 1'b0; bus.in_break = 1'b0; bus.clr_overflow = 1'b0;

    // Asynchronous reset in the middle of a cycle with data queued.
    busy_mode = 1;
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    #3 resetn = 1'b0;
    #1;
    chk("t1_tx_en",   32'(bus.tx_en),      32'd0);
    chk("t1_tx_data", 32'(bus.tx_data),    32'd0);
    chk("t1_fill",    32'(bus.fill_level), 32'd0);
    chk("t1_empty",   32'(bus.empty),      32'd1);
    chk("t1_full",    32'(bus.full),       32'd0);
    chk("t1_ovf",     32'(bus.overflow),   32'd0);
    tick(2);
    resetn = 1'b1;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
